// File: rtl/uram_port_ctrl_if.sv
// Command/response stream bundle between a client and uram_port_ctrl.
interface uram_port_ctrl_if #(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned DATA_W = 72
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_wr, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/uram_port_ctrl.sv
// Single-port URAM front-end: credit-limited command issue, read-latency
// tracking and an in-order show-ahead response FIFO.
module uram_port_ctrl #(
  parameter int unsigned ADDR_W    = 23,
  parameter int unsigned DATA_W    = 72,
  parameter int unsigned RD_LAT    = 3,
  parameter int unsigned RSP_DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  uram_port_ctrl_if.slave              if_cmd,
  output logic                         o_mem_en,
  output logic                         o_mem_rdb_wr,
  output logic [ADDR_W-1:0]            o_mem_addr,
  output logic [DATA_W-1:0]            o_mem_din,
  input  logic [DATA_W-1:0]            i_mem_dout,
  output logic [$clog2(RSP_DEPTH):0]   o_rd_outstanding,
  output logic                         o_busy
);
  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]  r_outstanding;
  logic [RD_LAT:0]   r_rd_pipe;
  logic [DATA_W-1:0] r_fifo [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_mem_en;
  logic              r_mem_rdb_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;

  logic              w_req_ready;
  logic              w_accept;
  logic              w_rd_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic [PTR_W-1:0]  w_rptr_nxt;
  logic [DATA_W-1:0] w_rsp_data_nxt;

  assign w_req_ready = (r_outstanding < CNT_W'(RSP_DEPTH));
  assign w_accept    = if_cmd.req_valid && w_req_ready;
  assign w_rd_accept = w_accept && !if_cmd.req_wr;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(RSP_DEPTH));
  assign w_push      = r_rd_pipe[RD_LAT];
  assign w_pop       = if_cmd.rsp_ready && !w_empty;
  assign w_rptr_nxt  = r_rptr + 1'b1;

  assign if_cmd.req_ready = w_req_ready;
  assign if_cmd.rsp_valid = !w_empty;
  assign if_cmd.rsp_data  = r_rsp_data;
  assign o_mem_en         = r_mem_en;
  assign o_mem_rdb_wr     = r_mem_rdb_wr;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_din        = r_mem_din;
  assign o_rd_outstanding = r_outstanding;
  assign o_busy           = (r_outstanding != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem_en     <= 1'b0;
      r_mem_rdb_wr <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
    end else begin
      r_mem_en <= w_accept;
      if (w_accept) begin
        r_mem_rdb_wr <= if_cmd.req_wr;
        r_mem_addr   <= if_cmd.req_addr;
        if (if_cmd.req_wr) r_mem_din <= if_cmd.req_data;
      end
    end
  end

  // Stage 0 is loaded on the accept edge; the URAM samples one edge later,
  // so the flag leaving stage RD_LAT lines up with valid i_mem_dout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rd_pipe <= '0;
    else       r_rd_pipe <= {r_rd_pipe[RD_LAT-1:0], w_rd_accept};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_rd_accept, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wptr] <= i_mem_dout;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= w_rptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is kept in its own register so the output holds its last value
  // once the FIFO drains.
  always_comb begin
    w_rsp_data_nxt = r_rsp_data;
    if (w_pop) begin
      if (r_count > CNT_W'(1)) w_rsp_data_nxt = r_fifo[w_rptr_nxt];
      else if (w_push)         w_rsp_data_nxt = i_mem_dout;
    end else if (w_empty && w_push) begin
      w_rsp_data_nxt = i_mem_dout;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rsp_data <= '0;
    else       r_rsp_data <= w_rsp_data_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) assert (!(w_push && w_full));
  end
endmodule

// File: tb/tb_uram_port_ctrl.sv
// Directed bench for uram_port_ctrl with a behavioural URAM and a response scoreboard.
module tb_uram_port_ctrl;
  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 72;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_en, mem_rdb_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic [3:0]        outstanding;
  logic              busy;

  uram_port_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  uram_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .RSP_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .if_cmd(bus),
    .o_mem_en(mem_en), .o_mem_rdb_wr(mem_rdb_wr), .o_mem_addr(mem_addr),
    .o_mem_din(mem_din), .i_mem_dout(mem_dout),
    .o_rd_outstanding(outstanding), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural URAM: write-first array, RD_LAT-cycle registered read path.
  logic [DATA_W-1:0] uram [64];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rdb_wr) uram[mem_addr[5:0]] <= mem_din;
      else            rd_pipe[0] <= uram[mem_addr[5:0]];
    end
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_dout = rd_pipe[RD_LAT-1];

  int n_total = 0;
  int n_pass  = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] shadow [64];

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] wdata(input int unsigned i);
    return {8'h3C, 32'(32'h1000_0000 + i), 32'(32'hFEED_0000 ^ i)};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: a pop happens at the next edge when valid && ready.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rsp_unexpected: got %h expected no response", bus.rsp_data);
      end else begin
        check("rsp_data", bus.rsp_data, exp_q.pop_front());
      end
    end
  end

  task automatic drain(input string name);
    int unsigned guard = 0;
    bus.rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || outstanding != 0) && guard < 100) begin
      step();
      guard++;
    end
    check(name, 72'(guard < 100), 72'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n_acc, miss, bad_rdy, en_cnt, bad_out, first_k;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
    bus.req_data = '0; bus.rsp_ready = 1'b0;

    // Power-on reset
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_mem_en", 72'(mem_en), 72'd0);
    check("rst_rsp_valid", 72'(bus.rsp_valid), 72'd0);
    check("rst_outstanding", 72'(outstanding), 72'd0);
    check("rst_ready", 72'(bus.req_ready), 72'd1);

    // Write then read, same address
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 23'h000005;
    bus.req_data = 72'h00_DEAD_BEEF_CAFE_F00D;
    shadow[5] = 72'h00_DEAD_BEEF_CAFE_F00D;
    step();
    check("wr_mem_en", 72'(mem_en), 72'd1);
    check("wr_rdb_wr", 72'(mem_rdb_wr), 72'd1);
    check("wr_din", mem_din, 72'h00_DEAD_BEEF_CAFE_F00D);
    bus.req_wr = 1'b0;
    exp_q.push_back(shadow[5]);
    step();
    bus.req_valid = 1'b0;
    check("rd_mem_en", 72'(mem_en), 72'd1);
    check("rd_rdb_wr", 72'(mem_rdb_wr), 72'd0);
    check("rd_addr", 72'(mem_addr), 72'h5);
    first_k = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (bus.rsp_valid && first_k == 0) first_k = k;
    end
    check("rd_latency", 72'(first_k), 72'd4);
    drain("drain_raw");

    // Write streaming with consumer stalled
    bus.rsp_ready = 1'b0;
    bad_rdy = 0; en_cnt = 0; bad_out = 0;
    for (int i = 0; i < 20; i++) begin
      bus.req_valid = 1'b1; bus.req_wr = 1'b1;
      bus.req_addr = 23'(i); bus.req_data = wdata(i);
      shadow[i] = wdata(i);
      if (!bus.req_ready) bad_rdy++;
      step();
      if (mem_en) en_cnt++;
      if (outstanding != 0) bad_out++;
    end
    bus.req_valid = 1'b0;
    step();
    check("ws_ready", 72'(bad_rdy), 72'd0);
    check("ws_en_cycles", 72'(en_cnt), 72'd20);
    check("ws_outstanding", 72'(bad_out), 72'd0);
    check("ws_en_drop", 72'(mem_en), 72'd0);
    miss = 0;
    for (int i = 0; i < 20; i++) if (uram[i] !== wdata(i)) miss++;
    check("ws_uram_contents", 72'(miss), 72'd0);

    // Credit stall: reads 0..9 with consumer held off
    n_acc = 0;
    for (int a = 0; a < 10; a++) begin
      bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 23'(a);
      if (bus.req_ready) begin
        exp_q.push_back(shadow[a]);
        n_acc++;
      end
      step();
    end
    bus.req_valid = 1'b0;
    check("cs_accepted", 72'(n_acc), 72'd8);
    check("cs_ready_low", 72'(bus.req_ready), 72'd0);
    check("cs_outstanding", 72'(outstanding), 72'd8);
    check("cs_busy", 72'(busy), 72'd1);
    repeat (RD_LAT + 2) step();
    bus.rsp_ready = 1'b1;
    miss = 0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.rsp_valid) miss++;
      step();
    end
    check("cs_one_per_cycle", 72'(miss), 72'd0);
    check("cs_drained", 72'(outstanding), 72'd0);
    check("cs_ready_back", 72'(bus.req_ready), 72'd1);
    check("cs_rsp_idle", 72'(bus.rsp_valid), 72'd0);

    // Simultaneous read accept and response pop at 7 outstanding
    bus.rsp_ready = 1'b0;
    for (int a = 10; a < 17; a++) begin
      bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 23'(a);
      exp_q.push_back(shadow[a]);
      step();
    end
    bus.req_valid = 1'b0;
    repeat (5) step();
    check("sim_pre_out", 72'(outstanding), 72'd7);
    bus.req_valid = 1'b1; bus.req_addr = 23'd17; bus.rsp_ready = 1'b1;
    exp_q.push_back(shadow[17]);
    step();
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    check("sim_post_out", 72'(outstanding), 72'd7);
    drain("drain_sim");

    // Reset with three reads in flight and the FIFO empty
    for (int a = 0; a < 3; a++) begin
      bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 23'(a);
      step();
    end
    bus.req_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("arst_mem_en", 72'(mem_en), 72'd0);
    check("arst_outstanding", 72'(outstanding), 72'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    miss = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.rsp_valid) miss++;
    end
    check("arst_no_rsp", 72'(miss), 72'd0);
    check("arst_out_zero", 72'(outstanding), 72'd0);
    check("arst_busy", 72'(busy), 72'd0);
    check("arst_ready", 72'(bus.req_ready), 72'd1);

    // Final read-back through the DUT after reset
    for (int a = 18; a < 20; a++) begin
      bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 23'(a);
      exp_q.push_back(shadow[a]);
      step();
    end
    bus.req_valid = 1'b0;
    drain("drain_final");
    check("scoreboard_empty", 72'(exp_q.size()), 72'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
